// File: rtl/rbz_tex_flash_reader.sv
// rbz_tex_flash_reader: quad-output (0x6B) SPI flash texel burst reader.
// Each SCLK period is a low phase then a high phase of one clk each.
module rbz_tex_flash_reader #(
  parameter logic [7:0]  CMD         = 8'h6B,
  parameter int unsigned DUMMY_SCLKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  input  logic [5:0]  i_len,
  output logic        o_busy,
  output logic [5:0]  o_data,
  output logic        o_valid,
  output logic        o_tex_csb,
  output logic        o_tex_sclk,
  output logic        o_tex_out0,
  output logic        o_tex_oeb0,
  input  logic [3:0]  i_tex_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DESEL
  } state_t;

  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_SCLKS - 1);

  state_t      state_q, state_d;
  logic        ph_q, ph_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [6:0]  len_q, len_d;
  logic        nib_q, nib_d;
  logic [2:0]  hi_q, hi_d;
  logic [5:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        active;
  logic        drive;
  logic        unused_io3;

  assign unused_io3 = i_tex_in[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= 5'd0;
      sh_q    <= 32'd0;
      len_q   <= 7'd0;
      nib_q   <= 1'b0;
      hi_q    <= 3'd0;
      data_q  <= 6'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      nib_q   <= nib_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    len_d   = len_q;
    nib_d   = nib_q;
    hi_d    = hi_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_req) begin
          state_d = S_CMD;
          ph_d    = 1'b0;
          cnt_d   = 5'd0;
          sh_d    = {CMD, i_addr};
          len_d   = (i_len == 6'd0) ? 7'd64 : {1'b0, i_len};
          nib_d   = 1'b0;
        end
      end
      S_CMD: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          sh_d  = {sh_q[30:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            state_d = S_ADDR;
            cnt_d   = 5'd0;
          end
        end
      end
      S_ADDR: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          sh_d  = {sh_q[30:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            state_d = S_DUMMY;
            cnt_d   = 5'd0;
          end
        end
      end
      S_DUMMY: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == DUMMY_LAST) begin
            state_d = S_DATA;
            cnt_d   = 5'd0;
            nib_d   = 1'b0;
          end
        end
      end
      S_DATA: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          nib_d = ~nib_q;
          if (!nib_q) begin
            hi_d = i_tex_in[2:0];
          end else begin
            data_d  = {hi_q, i_tex_in[2:0]};
            valid_d = 1'b1;
            len_d   = len_q - 7'd1;
            // last texel: release the flash on the same edge
            if (len_q == 7'd1) begin
              state_d = S_DESEL;
              cnt_d   = 5'd0;
              ph_d    = 1'b0;
            end
          end
        end
      end
      S_DESEL: begin
        ph_d  = 1'b0;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd2) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign active = (state_q == S_CMD) || (state_q == S_ADDR) ||
                  (state_q == S_DUMMY) || (state_q == S_DATA);
  assign drive  = (state_q == S_CMD) || (state_q == S_ADDR);

  assign o_busy     = (state_q != S_IDLE);
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_tex_csb  = ~active;
  assign o_tex_sclk = active & ph_q;
  assign o_tex_out0 = drive & sh_q[31];
  assign o_tex_oeb0 = ~drive;

endmodule
